// File: rtl/cpld_signal_readback.sv
// Host-read responder: synchronises IOR_N and snapshots gains/mode/update count onto IN_SD[15:8].
// Latency: data and IN_SD_OE valid SYNC_STAGES clocks after IOR_N is first sampled low; release takes the same.
// Backpressure: none; the host strobe paces reads, and IN_SD holds constant for the whole read.
//
// Ports: clk/rst (async active-high), IOR_N (async read strobe), ADDR (register select),
//        PID_PR/PID_INR/MODE (values currently driven by the board), IN_SD/IN_SD_OE (read data + pad enable).
// Optional feature: define SIGNAL_READBACK_CHECKSUM_EN to return an XOR checksum at address 4.
module cpld_signal_readback #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IOR_N,
    input  logic [2:0]  ADDR,
    input  logic [7:0]  PID_PR,
    input  logic [7:0]  PID_INR,
    input  logic [2:0]  MODE,
    output logic [15:8] IN_SD,
    output logic        IN_SD_OE
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("cpld_signal_readback: SYNC_STAGES must be 2 or 3");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ior_sync_q, ior_sync_d;
    logic                   ior_prev_q, ior_prev_d;
    logic [2:0]             addr_q, addr_d;
    logic [7:0]             in_sd_q, in_sd_d;
    logic [7:0]             upd_cnt_q, upd_cnt_d;
    logic [7:0]             prev_pr_q, prev_pr_d;
    logic [7:0]             prev_inr_q, prev_inr_d;

    logic                   ior_s;
    logic                   ior_fall;
    logic                   gain_chg;
    logic                   cnt_clr;
    logic [7:0]             rd_sel;

    // Synchroniser: new strobe sample enters at bit 0, ior_s is the last stage.
    always_comb begin
        ior_sync_d = {ior_sync_q[SYNC_STAGES-2:0], IOR_N};
    end

    assign ior_s    = ior_sync_q[SYNC_STAGES-1];
    assign ior_fall = ior_prev_q & ~ior_s;

    always_comb begin
        ior_prev_d = ior_s;
        prev_pr_d  = PID_PR;
        prev_inr_d = PID_INR;
    end

    // Register read mux, evaluated on the live ADDR at the snapshot edge.
    always_comb begin
        rd_sel = 8'h00;
        case (ADDR)
            3'd0:    rd_sel = PID_PR;
            3'd1:    rd_sel = PID_INR;
            3'd2:    rd_sel = {5'b0, MODE};
            3'd3:    rd_sel = upd_cnt_q;
`ifdef SIGNAL_READBACK_CHECKSUM_EN
            3'd4:    rd_sel = PID_PR ^ PID_INR ^ {5'b0, MODE} ^ upd_cnt_q;
`else
            3'd4:    rd_sel = 8'h00;
`endif
            default: rd_sel = 8'h00;
        endcase
    end

    // Read FSM: snapshot on synchronised falling edge, release when strobe returns high.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        in_sd_d = in_sd_q;
        cnt_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ior_fall) begin
                    state_d = S_DRIVE;
                    addr_d  = ADDR;
                    in_sd_d = rd_sel;
                end
            end
            S_DRIVE: begin
                if (ior_s) begin
                    state_d = S_IDLE;
                    // Reading the counter acknowledges it: clear on release.
                    cnt_clr = (addr_q == 3'd3);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Update counter: a change coinciding with the clear survives as a count of 1.
    always_comb begin
        gain_chg = (PID_PR != prev_pr_q) || (PID_INR != prev_inr_q);
        if (cnt_clr) begin
            upd_cnt_d = gain_chg ? 8'd1 : 8'd0;
        end else if (gain_chg && (upd_cnt_q != 8'hFF)) begin
            upd_cnt_d = upd_cnt_q + 8'd1;
        end else begin
            upd_cnt_d = upd_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ior_sync_q <= '1;
            ior_prev_q <= 1'b1;
            addr_q     <= 3'd0;
            in_sd_q    <= 8'h00;
            upd_cnt_q  <= 8'h00;
            prev_pr_q  <= 8'h00;
            prev_inr_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            ior_sync_q <= ior_sync_d;
            ior_prev_q <= ior_prev_d;
            addr_q     <= addr_d;
            in_sd_q    <= in_sd_d;
            upd_cnt_q  <= upd_cnt_d;
            prev_pr_q  <= prev_pr_d;
            prev_inr_q <= prev_inr_d;
        end
    end

    assign IN_SD    = in_sd_q;
    assign IN_SD_OE = (state_q == S_DRIVE);

endmodule

// File: tb/tb_cpld_signal_readback.sv
`timescale 1ns/1ps
module tb_cpld_signal_readback;

    localparam int SS = 2;

    logic        clk;
    logic        rst;
    logic        IOR_N;
    logic [2:0]  ADDR;
    logic [7:0]  PID_PR;
    logic [7:0]  PID_INR;
    logic [2:0]  MODE;
    logic [15:8] IN_SD;
    logic        IN_SD_OE;

    int checks = 0;
    int errors = 0;

    cpld_signal_readback #(.SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .IOR_N    (IOR_N),
        .ADDR     (ADDR),
        .PID_PR   (PID_PR),
        .PID_INR  (PID_INR),
        .MODE     (MODE),
        .IN_SD    (IN_SD),
        .IN_SD_OE (IN_SD_OE)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    // Reference model: every edge number, the input values seen there, and the
    // edges at which the gain pair differed from the previous edge (or from 0 after reset).
    int         cyc = 0;
    int         m_clr = 0;
    int         chg_q[$];
    logic [7:0] pr_hist   [int];
    logic [7:0] inr_hist  [int];
    logic [2:0] mode_hist [int];
    logic [7:0] m_prev_pr = 8'h00;
    logic [7:0] m_prev_inr = 8'h00;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_prev_pr  = 8'h00;
            m_prev_inr = 8'h00;
            chg_q.delete();
        end else begin
            if (PID_PR != m_prev_pr || PID_INR != m_prev_inr) chg_q.push_back(cyc);
            m_prev_pr  = PID_PR;
            m_prev_inr = PID_INR;
        end
        pr_hist[cyc]   = PID_PR;
        inr_hist[cyc]  = PID_INR;
        mode_hist[cyc] = MODE;
    end

    // Value the host should read for address a snapshotted at edge s.
    function automatic logic [7:0] model_val(input logic [2:0] a, input int s);
        int n = 0;
        logic [7:0] cnt;
        logic [7:0] r;
        foreach (chg_q[i]) if (chg_q[i] >= m_clr && chg_q[i] < s) n++;
        cnt = (n > 255) ? 8'hFF : n[7:0];
        case (a)
            3'd0:    r = pr_hist[s];
            3'd1:    r = inr_hist[s];
            3'd2:    r = {5'b0, mode_hist[s]};
            3'd3:    r = cnt;
`ifdef SIGNAL_READBACK_CHECKSUM_EN
            3'd4:    r = pr_hist[s] ^ inr_hist[s] ^ {5'b0, mode_hist[s]} ^ cnt;
`endif
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One host read. jitter perturbs the inputs while the data is driven;
    // rel_chg changes PID_PR so it lands on the release edge.
    task automatic do_read(input logic [2:0] a, input int hold, input bit jitter,
                           input bit rel_chg, output logic [7:0] got);
        int k, s, j, c;
        logic [7:0] exp;
        @(negedge clk);
        ADDR  = a;
        IOR_N = 1'b0;
        k = cyc + 1;
        s = k + SS;
        while (cyc < s - 1) @(negedge clk);
        chk("oe_before_snap", {7'd0, IN_SD_OE}, 8'h00);
        @(negedge clk);
        exp = model_val(a, s);
        got = IN_SD;
        chk("oe_at_snap", {7'd0, IN_SD_OE}, 8'h01);
        chk($sformatf("rd_addr%0d", a), IN_SD, exp);
        for (int h = 0; h < hold; h++) begin
            if (jitter) begin
                PID_PR  = PID_PR ^ 8'h33;
                PID_INR = PID_INR + 8'd1;
                MODE    = MODE ^ 3'd1;
            end
            @(negedge clk);
        end
        chk("sd_stable_drive", IN_SD, exp);
        IOR_N = 1'b1;
        j = cyc + 1;
        c = j + SS;
        while (cyc < c - 1) @(negedge clk);
        chk("oe_before_rel", {7'd0, IN_SD_OE}, 8'h01);
        if (rel_chg) PID_PR = PID_PR + 8'd1;
        @(negedge clk);
        chk("oe_after_rel", {7'd0, IN_SD_OE}, 8'h00);
        chk("sd_hold_idle", IN_SD, exp);
        if (a == 3'd3) m_clr = c;
    endtask

    logic [7:0] got;

    initial begin
        rst = 1'b1; IOR_N = 1'b1; ADDR = 3'd0;
        PID_PR = 8'h00; PID_INR = 8'h00; MODE = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_sd", IN_SD, 8'h00);
        chk("rst_oe", {7'd0, IN_SD_OE}, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // All-zero inputs: every address reads zero.
        for (int a = 0; a < 8; a++) begin
            do_read(a[2:0], 2, 1'b0, 1'b0, got);
            chk("zero_rd", got, 8'h00);
        end

        // Gains and mode readback.
        PID_PR = 8'h5A; PID_INR = 8'hC3; MODE = 3'b101;
        do_read(3'd0, 2, 1'b0, 1'b0, got); chk("pr_5a", got, 8'h5A);
        do_read(3'd1, 2, 1'b0, 1'b0, got); chk("inr_c3", got, 8'hC3);
        do_read(3'd2, 2, 1'b0, 1'b0, got); chk("mode_05", got, 8'h05);

        // Update counter: three changes, clear-on-read, saturation.
        do_read(3'd3, 2, 1'b0, 1'b0, got);
        for (int i = 0; i < 3; i++) begin
            PID_PR = PID_PR + 8'd1;
            @(negedge clk);
        end
        do_read(3'd3, 2, 1'b0, 1'b0, got); chk("cnt_3", got, 8'h03);
        do_read(3'd3, 2, 1'b0, 1'b0, got); chk("cnt_cleared", got, 8'h00);
        for (int i = 0; i < 300; i++) begin
            PID_PR = PID_PR + 8'd1;
            @(negedge clk);
        end
        do_read(3'd3, 2, 1'b0, 1'b0, got); chk("cnt_sat", got, 8'hFF);

        // Change coinciding with the clearing release counts once.
        do_read(3'd3, 2, 1'b0, 1'b1, got);
        do_read(3'd3, 2, 1'b0, 1'b0, got); chk("cnt_clr_inc", got, 8'h01);

        // Snapshot is frozen while driving.
        PID_PR = 8'h11;
        @(negedge clk);
        do_read(3'd0, 3, 1'b1, 1'b0, got); chk("frozen_11", got, 8'h11);

        // Checksum (or zero) at address 4.
        PID_PR = 8'h00; PID_INR = 8'h00; MODE = 3'd0;
        repeat (2) @(negedge clk);
        do_read(3'd3, 2, 1'b0, 1'b0, got);
        PID_PR = 8'hF0;
        @(negedge clk);
        PID_INR = 8'h0F; MODE = 3'b001;
        @(negedge clk);
`ifdef SIGNAL_READBACK_CHECKSUM_EN
        do_read(3'd4, 2, 1'b0, 1'b0, got); chk("csum_fc", got, 8'hFC);
`else
        do_read(3'd4, 2, 1'b0, 1'b0, got); chk("csum_off", got, 8'h00);
`endif

        // Randomized reads against the model.
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 6);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 1) PID_PR = 8'($urandom);
                if ($urandom_range(0, 2) == 0) PID_INR = 8'($urandom);
                if ($urandom_range(0, 3) == 0) MODE = 3'($urandom);
                @(negedge clk);
            end
            do_read(3'($urandom), $urandom_range(1, 4), 1'($urandom), 1'($urandom), got);
        end

        // Reset in the middle of a read.
        PID_PR = 8'h33;
        @(negedge clk);
        ADDR = 3'd0; IOR_N = 1'b0;
        repeat (SS + 1) @(negedge clk);
        chk("mid_oe_pre", {7'd0, IN_SD_OE}, 8'h01);
        #100 rst = 1'b1;
        #1;
        chk("mid_rst_oe", {7'd0, IN_SD_OE}, 8'h00);
        chk("mid_rst_sd", IN_SD, 8'h00);
        IOR_N = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(3'd3, 2, 1'b0, 1'b0, got); chk("cnt_after_rst", got, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if something stalls the stimulus.
    initial begin
        #60000000;
        errors++;
        $display("FAIL timeout got stalled exp finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
